elastic_proxy: RTL and testbench
================================

// Module: elastic_proxy
// PURPOSE
//  Parametrised successor to the single-entry valid/ready proxy: a DEPTH-entry elastic
//  buffer between an upstream valid/ready producer and a downstream consumer.
//  All outputs are registered, so no combinational path exists up_* <-> down_*.
//  Sustains one transfer per cycle under continuous flow; absorbs DEPTH beats of backpressure.
//  Used as a timing/decoupling slice on any streaming handshake link.
// PARAMETERS
//  DATA_W  8  payload width in bits
//  DEPTH   2  entries; legal range 2..256; not required to be a power of two
//  CNT_W   $clog2(DEPTH+1)  occupancy counter width (derived, localparam)
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  up_data     in   DATA_W   upstream payload
//  up_valid    in   1        upstream beat offered
//  up_ready    out  1        buffer can accept (registered)
//  down_data   out  DATA_W   head-of-buffer payload (registered)
//  down_valid  out  1        head entry present (registered)
//  down_ready  in   1        downstream accepts head
//  level       out  CNT_W    occupancy (only when ELASTIC_LEVEL_EN is defined)
// BEHAVIOUR
//  - Reset (async assert, sync release via clk): count=0, wr_ptr=rd_ptr=0,
//    up_ready=1, down_valid=0, down_data=0, level=0. Storage array is not reset.
//  - push = up_valid & up_ready; pop = down_valid & down_ready; both evaluated each edge.
//  - Handshake: payload is transferred on a clk edge where valid&ready are both high.
//    down_valid never drops and down_data never changes while down_valid=1 & down_ready=0.
//    up_valid may be asserted/dropped freely; up_ready does not depend on up_valid.
//  - Latency: a beat pushed at edge N is visible on down_data/down_valid after edge N (1 cycle),
//    including when the buffer was empty (no bypass path).
//  - Count update: push&!pop -> +1; pop&!push -> -1; push&pop -> unchanged; neither -> unchanged.
//  - up_ready_next = (count_next != DEPTH); down_valid_next = (count_next != 0).
//  - Full (count==DEPTH): up_ready=0, no push even if pop occurs that edge; ready reasserts
//    the cycle after the pop. Full throughput therefore needs DEPTH>=2.
//  - Empty with push: entry written, down_valid=1 next cycle.
//  - Pointers wrap DEPTH-1 -> 0 explicitly (compare, not modulo of 2^n).
//  - down_data is loaded from the entry at rd_ptr_next every edge (registered head read).
//  - Order preserved strictly FIFO; no drop, no duplication.
//  - Reset mid-operation: all stored beats discarded; outputs return to reset values at once.
// CONFIGURATION
//  - ELASTIC_LEVEL_EN defined: adds output port level = count (registered, updates same edge
//    as up_ready/down_valid, range 0..DEPTH).
//  - Not defined: port absent; count still exists internally; behaviour otherwise identical.
// STRUCTURE
//  - Shared package hs_pkg: localparam helper for CNT_W, typedef hs_beat_t (data+valid) for benches.
//  - One sub-module: elastic_proxy_mem (DEPTH x DATA_W register array, 1 write port,
//    1 async read port at an address); control/pointers/count stay in elastic_proxy.
// TESTING (DATA_W=8, DEPTH=4 unless stated; bench checks strict increasing sequence from 0)
//  - Reset: after rst_n pulse -> up_ready=1, down_valid=0, level=0; no transfer for 2 cycles.
//  - Streaming: up_valid=1, down_ready=1 for 100 cycles -> 1 beat/cycle after 1-cycle latency,
//    data 0,1,2,... with no gaps.
//  - Backpressure: down_ready=0 with up_valid=1 -> exactly 4 beats accepted, up_ready=0,
//    level=4; release down_ready -> data 0..3 then continues with 4, none lost.
//  - Alternating: up_valid toggles each cycle, down_ready toggles each cycle (offset phase)
//    -> order kept, down_data stable while down_valid & !down_ready.
//  - Full + pop same edge: at level=4 assert down_ready with up_valid=1 -> no push that edge,
//    level=3, up_ready=1 next cycle.
//  - Mid-stream reset with level=3 -> down_valid=0, level=0 immediately; first beat after
//    release is the new stream's 0. Repeat streaming test with DEPTH=2 and DEPTH=5 (wrap).

Source files
------------

// File: rtl/hs_pkg.sv
// hs_pkg: shared handshake helpers (counter width helper, bench beat type)
package hs_pkg;
  localparam int HS_DATA_W = 8;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  typedef struct packed {
    logic [HS_DATA_W-1:0] data;
    logic                 valid;
  } hs_beat_t;
endpackage

// File: rtl/elastic_proxy_mem.sv
// elastic_proxy_mem: DEPTH x DATA_W register array, one write port, one async read port
module elastic_proxy_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  // storage is intentionally not reset
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/elastic_proxy.sv
// elastic_proxy: DEPTH-entry registered elastic buffer on a valid/ready link; ELASTIC_LEVEL_EN adds the level output
module elastic_proxy
  import hs_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] up_data,
  input  logic              up_valid,
  output logic              up_ready,
  output logic [DATA_W-1:0] down_data,
  output logic              down_valid,
  input  logic              down_ready
`ifdef ELASTIC_LEVEL_EN
  ,
  output logic [CNT_W-1:0]  level
`endif
);
  logic [CNT_W-1:0]  count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              up_ready_q, up_ready_d, down_valid_q, down_valid_d;
  logic [DATA_W-1:0] down_data_q, down_data_d, rd_data;
  logic              push, pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  elastic_proxy_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (up_data),
    .raddr (rd_ptr_d),
    .rdata (rd_data)
  );

  // next-state: handshakes, pointers, occupancy and the registered head; a beat written into the slot that becomes head is forwarded from up_data
  always_comb begin
    push         = up_valid & up_ready_q;
    pop          = down_valid_q & down_ready;
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d     = push ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = pop ? nxt(rd_ptr_q) : rd_ptr_q;
    up_ready_d   = count_d != CNT_W'(DEPTH);
    down_valid_d = count_d != '0;
    down_data_d  = (count_d == '0) ? down_data_q :
                   (push && wr_ptr_q == rd_ptr_d) ? up_data : rd_data;
  end

  // control and output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      up_ready_q   <= 1'b1;
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      up_ready_q   <= up_ready_d;
      down_valid_q <= down_valid_d;
      down_data_q  <= down_data_d;
    end

  assign up_ready   = up_ready_q;
  assign down_valid = down_valid_q;
  assign down_data  = down_data_q;
`ifdef ELASTIC_LEVEL_EN
  assign level      = count_q;
`endif
endmodule

// File: tb/tb_elastic_proxy.sv
// tb_elastic_proxy: directed checks of elastic_proxy at DEPTH 2, 4 and 5 (level checks when ELASTIC_LEVEL_EN is defined)
module tb_elastic_proxy;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up_valid = 1'b0;
  logic       down_ready = 1'b0;
  logic [7:0] ud [3];
  logic [7:0] dd [3];
  logic       ur [3];
  logic       dv [3];
  logic [7:0] exp_d [3];
  int         tests = 0;
  int         failed = 0;
`ifdef ELASTIC_LEVEL_EN
  logic [1:0] lvl2;
  logic [2:0] lvl4, lvl5;
`endif

  always #5 clk = ~clk;

  elastic_proxy #(.DATA_W(8), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .up_data(ud[0]), .up_valid(up_valid), .up_ready(ur[0]),
    .down_data(dd[0]), .down_valid(dv[0]), .down_ready(down_ready)
`ifdef ELASTIC_LEVEL_EN
    , .level(lvl2)
`endif
  );
  elastic_proxy #(.DATA_W(8), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .up_data(ud[1]), .up_valid(up_valid), .up_ready(ur[1]),
    .down_data(dd[1]), .down_valid(dv[1]), .down_ready(down_ready)
`ifdef ELASTIC_LEVEL_EN
    , .level(lvl4)
`endif
  );
  elastic_proxy #(.DATA_W(8), .DEPTH(5)) u_d5 (
    .clk(clk), .rst_n(rst_n), .up_data(ud[2]), .up_valid(up_valid), .up_ready(ur[2]),
    .down_data(dd[2]), .down_valid(dv[2]), .down_ready(down_ready)
`ifdef ELASTIC_LEVEL_EN
    , .level(lvl5)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: check pops against the per-instance sequence, advance source data on pushes, check head stability under stall
  task automatic tick();
    logic       p [3];
    logic       q [3];
    logic       h [3];
    logic [7:0] hd [3];
    for (int i = 0; i < 3; i++) begin
      p[i]  = up_valid & ur[i];
      q[i]  = dv[i] & down_ready;
      h[i]  = dv[i] & ~down_ready;
      hd[i] = dd[i];
      if (q[i]) chk($sformatf("pop_data%0d", i), dd[i], exp_d[i]);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (p[i]) ud[i] = ud[i] + 8'd1;
      if (q[i]) exp_d[i] = exp_d[i] + 8'd1;
      if (h[i]) begin
        chk($sformatf("hold_valid%0d", i), dv[i], 1'b1);
        chk($sformatf("hold_data%0d", i), dd[i], hd[i]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, failed + 1);
  end

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      ud[i] = '0;
      exp_d[i] = '0;
    end
    // reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_up_ready", ur[1], 1'b1);
    chk("rst_down_valid", dv[1], 1'b0);
    chk("rst_down_data", dd[1], 8'd0);
`ifdef ELASTIC_LEVEL_EN
    chk("rst_level", lvl4, 3'd0);
`endif
    rst_n = 1'b1;
    // no transfer while idle
    tick();
    chk("idle_valid_1", dv[1], 1'b0);
    tick();
    chk("idle_valid_2", dv[1], 1'b0);
    // backpressure: exactly DEPTH beats absorbed
    up_valid = 1'b1;
    down_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("bp_ready_k%0d", k), ur[1], (k < 4) ? 1'b1 : 1'b0);
      tick();
    end
    chk("bp_accepted", ud[1], 8'd4);
    chk("bp_down_valid", dv[1], 1'b1);
    chk("bp_head", dd[1], 8'd0);
`ifdef ELASTIC_LEVEL_EN
    chk("bp_level", lvl4, 3'd4);
`endif
    // full + pop on the same edge: no push, ready returns next cycle
    down_ready = 1'b1;
    tick();
    chk("fp_up_ready", ur[1], 1'b1);
    chk("fp_no_push", ud[1], 8'd4);
    chk("fp_head", dd[1], 8'd1);
`ifdef ELASTIC_LEVEL_EN
    chk("fp_level", lvl4, 3'd3);
`endif
    repeat (12) tick();
    chk("flow_popped", exp_d[1], 8'd13);
`ifdef ELASTIC_LEVEL_EN
    chk("flow_level", lvl4, 3'd3);
`endif
    // alternating valid/ready in opposite phase
    for (int k = 0; k < 20; k++) begin
      up_valid = k[0];
      down_ready = ~k[0];
      tick();
    end
    // drain, then fill to three entries
    up_valid = 1'b0;
    down_ready = 1'b1;
    n = 0;
    while ((dv[0] | dv[1] | dv[2]) && n < 20) begin
      tick();
      n++;
    end
    chk("drain_empty", dv[1], 1'b0);
    chk("drain_all_out", exp_d[1], ud[1]);
    up_valid = 1'b1;
    down_ready = 1'b0;
    repeat (3) tick();
    chk("pre_rst_valid", dv[1], 1'b1);
`ifdef ELASTIC_LEVEL_EN
    chk("pre_rst_level", lvl4, 3'd3);
`endif
    // asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("mrst_down_valid", dv[1], 1'b0);
    chk("mrst_up_ready", ur[1], 1'b1);
    chk("mrst_down_data", dd[1], 8'd0);
`ifdef ELASTIC_LEVEL_EN
    chk("mrst_level", lvl4, 3'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      ud[i] = '0;
      exp_d[i] = '0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    // continuous streaming on all depths
    up_valid = 1'b1;
    down_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lat_valid%0d", i), dv[i], 1'b1);
      chk($sformatf("lat_data%0d", i), dd[i], 8'd0);
    end
    for (int k = 1; k < 100; k++) begin
      tick();
      for (int i = 0; i < 3; i++)
        if (!dv[i] || !ur[i]) chk($sformatf("stream_gap%0d_k%0d", i, k), {dv[i], ur[i]}, 2'b11);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stream_pushed%0d", i), ud[i], 8'd100);
      chk($sformatf("stream_popped%0d", i), exp_d[i], 8'd99);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
